// File: rtl/alu_sched.sv
// alu_sched: round-robin front end that shares one combinational 16-bit ALU between two ports.
// Operands are registered and held for a per-op settle window; div/mod by zero never reaches the ALU.
module alu_sched #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_divz,
  output logic [15:0] alu_tmp1,
  output logic [15:0] alu_tmp2,
  output logic [2:0]  alu_op,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        last_grant, divz;
  logic        grant, accept, sel_divz, sel_slow;
  logic [2:0]  sel_op;
  logic [15:0] sel_a, sel_b;

  always_comb begin
    grant    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    sel_op   = grant ? req_op1 : req_op0;
    sel_a    = grant ? req_a1  : req_a0;
    sel_b    = grant ? req_b1  : req_b0;
    sel_divz = (sel_op == 3'b011 || sel_op == 3'b100) && (sel_b == 16'd0);
    // A zero-divisor op is resolved locally, so it gets the short settle window.
    sel_slow = (sel_op == 3'b010 || sel_op == 3'b011 || sel_op == 3'b100) && !sel_divz;
  end

  assign req_ready  = (state == IDLE) ? (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign accept     = |req_ready;
  assign alu_enable = (state == EXEC);
  assign rsp_valid  = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      divz       <= 1'b0;
      alu_tmp1   <= 16'd0;
      alu_tmp2   <= 16'd0;
      alu_op     <= 3'b000;
      rsp_id     <= 1'b0;
      rsp_result <= 16'd0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_divz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_tmp1   <= sel_a;
          alu_tmp2   <= sel_divz ? 16'd1 : sel_b;
          alu_op     <= sel_op;
          rsp_id     <= grant;
          last_grant <= grant;
          divz       <= sel_divz;
          cnt        <= sel_slow ? 4'(MULDIV_CYCLES - 1) : 4'd0;
          state      <= EXEC;
        end
        EXEC: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_result <= divz ? 16'd0 : alu_result;
          rsp_zero   <= divz ? 1'b1  : alu_zero;
          rsp_carry  <= divz ? 1'b0  : alu_carry;
          rsp_divz   <= divz;
          state      <= DONE;
        end
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: plays the ALU, drives two queued requesters, and checks every cycle
// against a timestamp-based transaction model plus literal expectations for the key scenarios.
module tb_alu_sched;
  localparam int MD = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  req_valid = 2'b00, req_ready;
  logic [2:0]  req_op0 = 3'd0, req_op1 = 3'd0;
  logic [15:0] req_a0 = 16'd0, req_b0 = 16'd0, req_a1 = 16'd0, req_b1 = 16'd0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, rsp_carry, rsp_divz;
  logic [15:0] rsp_result, alu_tmp1, alu_tmp2, alu_result;
  logic [2:0]  alu_op;
  logic        alu_enable, alu_zero, alu_carry;

  int vectors = 0, miscompares = 0;

  typedef struct { logic [2:0] op; logic [15:0] a; logic [15:0] b; } req_t;
  typedef struct { bit id; logic [15:0] res; bit z; bit c; bit dz; int lat; int en; logic [15:0] tmp2; int cyc; } hs_t;
  typedef struct { bit port; int cyc; } acc_t;

  req_t q0[$], q1[$];
  hs_t  hs_log[$];
  acc_t acc_log[$];

  bit bp_hold = 0, rr_rand = 0;
  bit [1:0] acc_flag = 2'b00;

  alu_sched #(.MULDIV_CYCLES(MD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_divz(rsp_divz), .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op),
    .alu_enable(alu_enable), .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Reference ALU: carry reports signed overflow of the 16-bit result.
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] aw, bw, w;
    logic [15:0] r;
    aw = 32'(signed'(a));
    bw = 32'(signed'(b));
    w  = 32'sd0;
    case (op)
      3'd0: w = aw + bw;
      3'd1: w = aw - bw;
      3'd2: w = aw * bw;
      3'd3: w = (bw == 0) ? 32'sd0 : aw / bw;
      3'd4: w = (bw == 0) ? 32'sd0 : aw % bw;
      default: w = 32'sd0;
    endcase
    r = w[15:0];
    return {(w != {{16{r[15]}}, r}), (r == 16'd0), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_op, alu_tmp1, alu_tmp2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: busy flag, cycles since accept, settle length, expected response.
  bit m_busy = 0, m_last = 1, m_id, m_z, m_c, m_dz;
  int m_cyc, m_n;
  req_t m_req;
  logic [15:0] m_res;
  int cyc = 0, last_acc = 0, rise_cyc = 0, en_cnt = 0;
  bit prev_rv = 0;
  logic [15:0] tmp2_seen = 16'd0;

  always @(negedge clk) begin
    bit g;
    logic [1:0] exp_rdy;
    if (reset) begin
      m_busy = 0; m_last = 1; acc_flag = 2'b00; prev_rv = 0;
      chk("rst req_ready", 32'(req_ready), 0);
      chk("rst rsp_valid", 32'(rsp_valid), 0);
      chk("rst alu_enable", 32'(alu_enable), 0);
      chk("rst alu_tmp1", 32'(alu_tmp1), 0);
      chk("rst alu_tmp2", 32'(alu_tmp2), 0);
      chk("rst alu_op", 32'(alu_op), 0);
      chk("rst rsp_flags", 32'({rsp_id, rsp_zero, rsp_carry, rsp_divz}), 0);
      chk("rst rsp_result", 32'(rsp_result), 0);
    end else begin
      // DUT-side event log used by the literal checks
      if (alu_enable) begin en_cnt++; tmp2_seen = alu_tmp2; end
      if ((req_valid & req_ready) != 2'b00) begin
        acc_log.push_back('{req_ready[1], cyc});
        last_acc = cyc; en_cnt = 0;
      end
      if (rsp_valid && !prev_rv) rise_cyc = cyc;
      if (rsp_valid && rsp_ready)
        hs_log.push_back('{rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_divz,
                           rise_cyc - last_acc, en_cnt, tmp2_seen, cyc});
      prev_rv = rsp_valid;

      g = (req_valid == 2'b11) ? !m_last : req_valid[1];
      exp_rdy = m_busy ? 2'b00 : (req_valid & (g ? 2'b10 : 2'b01));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("alu_enable", 32'(alu_enable), 32'(m_busy && m_cyc < m_n));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_cyc >= m_n));
      if (m_busy) begin
        chk("alu_tmp1", 32'(alu_tmp1), 32'(m_req.a));
        chk("alu_tmp2", 32'(alu_tmp2), m_dz ? 32'd1 : 32'(m_req.b));
        chk("alu_op", 32'(alu_op), 32'(m_req.op));
      end
      if (m_busy && m_cyc >= m_n) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_flags", 32'({rsp_zero, rsp_carry, rsp_divz}), 32'({m_z, m_c, m_dz}));
      end

      // Predict what the coming edge does.
      acc_flag = 2'b00;
      if (m_busy) begin
        if (m_cyc >= m_n) begin
          if (rsp_ready) m_busy = 0;
        end else m_cyc++;
      end else if (req_valid != 2'b00) begin
        m_req = g ? '{req_op1, req_a1, req_b1} : '{req_op0, req_a0, req_b0};
        m_dz  = (m_req.op == 3'd3 || m_req.op == 3'd4) && m_req.b == 16'd0;
        m_n   = (m_req.op >= 3'd2 && m_req.op <= 3'd4 && !m_dz) ? MD : 1;
        {m_c, m_z, m_res} = m_dz ? 18'h10000 : alu_f(m_req.op, m_req.a, m_req.b);
        m_id = g; m_last = g; m_busy = 1; m_cyc = 0;
        acc_flag[g] = 1'b1;
      end
    end
    cyc++;
  end

  // Requesters: hold the head of each queue until it is accepted.
  always @(posedge clk) begin
    #1;
    if (acc_flag[0] && q0.size() > 0) q0.delete(0);
    if (acc_flag[1] && q1.size() > 0) q1.delete(0);
    acc_flag = 2'b00;
    req_valid[0] = (q0.size() > 0);
    req_valid[1] = (q1.size() > 0);
    if (q0.size() > 0) begin req_op0 = q0[0].op; req_a0 = q0[0].a; req_b0 = q0[0].b; end
    if (q1.size() > 0) begin req_op1 = q1[0].op; req_a1 = q1[0].a; req_b1 = q1[0].b; end
    rsp_ready = bp_hold ? 1'b0 : (rr_rand ? ($urandom_range(3) != 0) : 1'b1);
  end

  task automatic wait_idle(input int budget);
    int t = 0;
    do begin @(posedge clk); t++; end
    while ((q0.size() > 0 || q1.size() > 0 || m_busy || acc_flag != 0) && t < budget);
    #2;
    vectors++;
    if (t >= budget) begin miscompares++; $display("FAIL wait_idle: timed out after %0d cycles", t); end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic chk_last(input string nm, input bit id, input logic [15:0] res,
                          input bit z, input bit c, input bit dz, input int lat);
    hs_t h;
    if (hs_log.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: no response logged", nm);
    end else begin
      h = hs_log[hs_log.size() - 1];
      chk({nm, " id"}, 32'(h.id), 32'(id));
      chk({nm, " result"}, 32'(h.res), 32'(res));
      chk({nm, " zcd"}, 32'({h.z, h.c, h.dz}), 32'({z, c, dz}));
      chk({nm, " latency"}, 32'(h.lat), 32'(lat));
    end
  endtask

  initial begin
    int n0, a0, t;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    q0.push_back('{3'd0, 16'h7FFF, 16'h0001});
    wait_idle(50);
    chk_last("add", 0, 16'h8000, 0, 1, 0, 2);

    q1.push_back('{3'd2, 16'd300, 16'hFFFE});
    wait_idle(50);
    chk_last("mul", 1, 16'hFDA8, 0, 0, 0, MD + 1);
    chk("mul enable cycles", 32'(hs_log[hs_log.size()-1].en), MD);

    q0.push_back('{3'd3, 16'd100, 16'd0});
    wait_idle(50);
    chk_last("div0", 0, 16'h0000, 1, 0, 1, 2);
    chk("div0 alu_tmp2", 32'(hs_log[hs_log.size()-1].tmp2), 1);
    q0.push_back('{3'd4, 16'd7, 16'd3});
    wait_idle(50);
    chk_last("mod", 0, 16'h0001, 0, 0, 0, MD + 1);

    // Backpressure with port 1 pending.
    bp_hold = 1;
    q0.push_back('{3'd0, 16'd5, 16'd6});
    t = 0;
    while (!(m_busy && m_cyc >= m_n) && t < 50) begin @(posedge clk); t++; end
    q1.push_back('{3'd1, 16'd1, 16'd2});
    repeat (10) @(posedge clk);
    bp_hold = 0;
    wait_idle(50);
    chk("bp responses", 32'(hs_log.size() >= 2), 1);
    if (hs_log.size() >= 2) begin
      chk("bp first result", 32'(hs_log[hs_log.size()-2].res), 32'd11);
      chk("bp second result", 32'(hs_log[hs_log.size()-1].res), 32'hFFFF);
      chk("bp accept after hs", 32'(acc_log[acc_log.size()-1].cyc - hs_log[hs_log.size()-2].cyc), 1);
      chk("bp accept port", 32'(acc_log[acc_log.size()-1].port), 1);
    end

    // Contention right after reset: port 0 first, then strict alternation.
    do_reset();
    a0 = acc_log.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{3'd0, 16'(i), 16'd1});
      q1.push_back('{3'd0, 16'(i), 16'd2});
    end
    wait_idle(200);
    chk("rr count", 32'(acc_log.size() - a0), 8);
    for (int i = 0; i < 8 && a0 + i < acc_log.size(); i++)
      chk("rr grant order", 32'(acc_log[a0 + i].port), 32'(i % 2));

    // Reset in the middle of a slow divide: no response, then normal service.
    q0.push_back('{3'd3, 16'd1000, 16'd7});
    t = 0;
    while (!alu_enable && t < 50) begin @(negedge clk); t++; end
    n0 = hs_log.size();
    do_reset();
    repeat (5) @(posedge clk);
    chk("no rsp after reset", 32'(hs_log.size()), 32'(n0));
    q1.push_back('{3'd1, 16'd10, 16'd3});
    wait_idle(50);
    chk("post-reset count", 32'(hs_log.size()), 32'(n0 + 1));
    chk_last("post-reset sub", 1, 16'd7, 0, 0, 0, 2);

    // Random traffic with random backpressure.
    rr_rand = 1;
    for (int i = 0; i < 300; i++) begin
      req_t r;
      r.op = 3'($urandom_range(7));
      r.a  = 16'($urandom);
      r.b  = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(1) == 0) q0.push_back(r); else q1.push_back(r);
    end
    wait_idle(20000);
    rr_rand = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
